rs_free_tracker: RTL and testbench

- Wakeup-side receiver of the Execute→Wakeup free protocol (free_en, free_index).
- Tracks the per-entry occupancy state of the reservation station.
- Allocates the lowest free entry to Dispatch, marks entries issued when Select sends them to Execute, and returns entries to the free pool when Execute reports completion.
- Sits between Dispatch (allocation), Select (issue marking) and Execute (free).

---
 rtl/rs_free_tracker.sv | 87 ++++++++
 tb/tb_rs_free_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_free_tracker.sv
// rs_free_tracker: reservation-station occupancy tracker (allocate lowest FREE, issue, free on completion).
// Optional macro WAKEUP_FLUSH_EN adds a flush input that returns every entry to FREE.
module rs_free_tracker #(
   parameter int RS_ENTRIES = 16,
   parameter int IDX_W      = $clog2(RS_ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef WAKEUP_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             alloc_req,
   output logic             alloc_grant,
   output logic [IDX_W-1:0] alloc_index,
   input  logic             issue_en,
   input  logic [IDX_W-1:0] issue_index,
   input  logic             free_en,
   input  logic [IDX_W-1:0] free_index,
   output logic [IDX_W:0]   free_count,
   output logic             full,
   output logic             empty,
   output logic             err_sticky
);

   // state    | meaning
   // S_FREE   | entry available for allocation
   // S_VALID  | allocated by Dispatch, waiting for Select
   // S_ISSUED | sent to Execute, waiting for free
   localparam logic [1:0] S_FREE   = 2'd0;
   localparam logic [1:0] S_VALID  = 2'd1;
   localparam logic [1:0] S_ISSUED = 2'd2;

   localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(RS_ENTRIES);

   logic [1:0]     st [RS_ENTRIES];
   logic [IDX_W:0] free_cnt_q;
   logic           err_q;
   logic           flush_act;
   logic           alloc_ok;
   logic           issue_ok;
   logic           free_ok;
   logic           err_evt;

`ifdef WAKEUP_FLUSH_EN
   assign flush_act = flush;
`else
   assign flush_act = 1'b0;
`endif

   // Lowest-numbered FREE entry; falls back to 0 when nothing is free.
   always_comb begin
      alloc_index = '0;
      for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
         if (st[i] == S_FREE) alloc_index = IDX_W'(i);
      end
   end

   assign full        = (free_cnt_q == '0);
   assign empty       = (free_cnt_q == CNT_MAX);
   assign alloc_grant = alloc_req & ~full & ~flush_act;
   assign alloc_ok    = alloc_grant;
   assign issue_ok    = issue_en & (st[issue_index] == S_VALID);
   assign free_ok     = free_en & (st[free_index] == S_ISSUED);
   assign err_evt     = (issue_en & ~issue_ok) | (free_en & ~free_ok);

   // Alloc, issue and free each act on a different registered state, so their targets never overlap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RS_ENTRIES; i++) st[i] <= S_FREE;
         free_cnt_q <= CNT_MAX;
         err_q      <= 1'b0;
      end else if (flush_act) begin
         for (int i = 0; i < RS_ENTRIES; i++) st[i] <= S_FREE;
         free_cnt_q <= CNT_MAX;
      end else begin
         if (alloc_ok) st[alloc_index] <= S_VALID;
         if (issue_ok) st[issue_index] <= S_ISSUED;
         if (free_ok)  st[free_index]  <= S_FREE;
         free_cnt_q <= free_cnt_q + (IDX_W+1)'(free_ok) - (IDX_W+1)'(alloc_ok);
         if (err_evt) err_q <= 1'b1;
      end
   end

   assign free_count = free_cnt_q;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_rs_free_tracker.sv
// Self-checking bench for rs_free_tracker: directed table, hand sequences and random traffic
// checked against an occupancy-array reference model.
module tb_rs_free_tracker;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       alloc_req;
   logic       alloc_grant;
   logic [3:0] alloc_index;
   logic       issue_en;
   logic [3:0] issue_index;
   logic       free_en;
   logic [3:0] free_index;
   logic [4:0] free_count;
   logic       full;
   logic       empty;
   logic       err_sticky;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: 0 = free, 1 = allocated, 2 = issued
   int m_st [N];
   bit m_err;

   typedef struct {
      bit req;
      bit exp_grant;
      int exp_idx;
      int exp_cnt;
   } vec_t;
   vec_t tbl [17];

   always #5 clk = ~clk;

   rs_free_tracker #(.RS_ENTRIES(N)) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef WAKEUP_FLUSH_EN
      .flush       (flush),
`endif
      .alloc_req   (alloc_req),
      .alloc_grant (alloc_grant),
      .alloc_index (alloc_index),
      .issue_en    (issue_en),
      .issue_index (issue_index),
      .free_en     (free_en),
      .free_index  (free_index),
      .free_count  (free_count),
      .full        (full),
      .empty       (empty),
      .err_sticky  (err_sticky)
   );

   function automatic int m_free();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_st[i] == 0) c++;
      return c;
   endfunction

   function automatic int m_low();
      for (int i = 0; i < N; i++) if (m_st[i] == 0) return i;
      return 0;
   endfunction

   function automatic int pick(int want);
      int cand[$];
      for (int i = 0; i < N; i++) if (m_st[i] == want) cand.push_back(i);
      if (cand.size() == 0 || $urandom_range(0, 99) < 15) return int'($urandom_range(0, N-1));
      return cand[$urandom_range(0, cand.size()-1)];
   endfunction

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_st[i] = 0;
      m_err = 1'b0;
   endtask

   task automatic do_reset();
      alloc_req = 0; issue_en = 0; free_en = 0; flush = 0;
      issue_index = '0; free_index = '0;
      rst = 1'b1;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Called just after a rising edge; checks outputs mid-cycle, then advances one edge.
   task automatic step(bit req, bit ien, int iidx, bit fen, int fidx, bit fl);
      int nf, lo;
      bit g, iok, fok;
      alloc_req = req; issue_en = ien; issue_index = 4'(iidx);
      free_en = fen; free_index = 4'(fidx); flush = fl;
      #2;
      nf = m_free();
      lo = m_low();
      g  = req && nf > 0 && !fl;
      chk("alloc_grant", int'(alloc_grant), int'(g));
      chk("alloc_index", int'(alloc_index), lo);
      chk("free_count",  int'(free_count), nf);
      chk("full",        int'(full),  int'(nf == 0));
      chk("empty",       int'(empty), int'(nf == N));
      chk("err_sticky",  int'(err_sticky), int'(m_err));
      @(posedge clk);
      if (fl) begin
         for (int i = 0; i < N; i++) m_st[i] = 0;
      end else begin
         iok = ien && m_st[iidx] == 1;
         fok = fen && m_st[fidx] == 2;
         if ((ien && !iok) || (fen && !fok)) m_err = 1'b1;
         if (g)   m_st[lo]   = 1;
         if (iok) m_st[iidx] = 2;
         if (fok) m_st[fidx] = 0;
      end
      #1;
      alloc_req = 0; issue_en = 0; free_en = 0; flush = 0;
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 17; i++)
         tbl[i] = '{req: 1'b1, exp_grant: (i < 16), exp_idx: (i < 16) ? i : 0, exp_cnt: 16 - i};

      do_reset();
      chk("reset_count", int'(free_count), 16);
      chk("reset_empty", int'(empty), 1);
      chk("reset_full",  int'(full), 0);
      chk("reset_err",   int'(err_sticky), 0);
      chk("reset_grant", int'(alloc_grant), 0);

      // Fill all entries from empty, then one request too many
      for (int i = 0; i < 17; i++) begin
         alloc_req = tbl[i].req;
         #1;
         chk("tbl_grant", int'(alloc_grant), int'(tbl[i].exp_grant));
         chk("tbl_index", int'(alloc_index), tbl[i].exp_idx);
         chk("tbl_count", int'(free_count), tbl[i].exp_cnt);
         step(tbl[i].req, 0, 0, 0, 0, 0);
      end
      chk("full_after_fill", int'(full), 1);
      chk("err_after_fill",  int'(err_sticky), 0);

      // Free-to-reuse: allocate 0..3, issue 2, free 2, next alloc returns 2
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0, 0);
      step(0, 0, 0, 1, 2, 0);
      chk("reuse_count", int'(free_count), 13);
      alloc_req = 1; #1;
      chk("reuse_index", int'(alloc_index), 2);
      chk("reuse_grant", int'(alloc_grant), 1);
      step(1, 0, 0, 0, 0, 0);

      // Alloc while full with a same-cycle free of entry 0
      do_reset();
      for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      alloc_req = 1; free_en = 1; free_index = 0; #1;
      chk("full_free_grant", int'(alloc_grant), 0);
      step(1, 0, 0, 1, 0, 0);
      chk("freed_count", int'(free_count), 1);
      step(1, 0, 0, 0, 0, 0);
      chk("realloc_count", int'(free_count), 0);
      chk("realloc_err",   int'(err_sticky), 0);

      // Illegal free of an allocated-but-not-issued entry
      do_reset();
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 5, 0);
      chk("bad_free_err",   int'(err_sticky), 1);
      chk("bad_free_count", int'(free_count), 10);
      step(0, 1, 5, 0, 0, 0);
      idle(3);
      chk("err_held", int'(err_sticky), 1);
      // Same-index issue+free: issue legal, free flagged
      step(0, 1, 4, 1, 4, 0);
      step(0, 1, 5, 1, 5, 0);

      // Async reset mid-cycle after 10 allocations and an error
      do_reset();
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
      step(0, 1, 12, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_count", int'(free_count), 16);
      chk("async_empty", int'(empty), 1);
      chk("async_err",   int'(err_sticky), 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      idle(1);

`ifdef WAKEUP_FLUSH_EN
      do_reset();
      for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, i, 0, 0, 0);
      alloc_req = 1; flush = 1; #1;
      chk("flush_grant", int'(alloc_grant), 0);
      step(1, 1, 15, 1, 14, 1);
      chk("flush_count", int'(free_count), 16);
      chk("flush_empty", int'(empty), 1);
      chk("flush_err",   int'(err_sticky), 0);
      idle(1);
`endif

      // Random traffic in short reset-separated segments
      for (int seg = 0; seg < 8; seg++) begin
         do_reset();
         for (int c = 0; c < 60; c++) begin
            bit r, ie, fe, fl;
            int ii, fi;
            r  = $urandom_range(0, 99) < 60;
            ie = $urandom_range(0, 99) < 45;
            fe = $urandom_range(0, 99) < 40;
            ii = pick(1);
            fi = pick(2);
            fl = 1'b0;
`ifdef WAKEUP_FLUSH_EN
            fl = $urandom_range(0, 99) < 3;
`endif
            step(r, ie, ii, fe, fi, fl);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
